// File: rtl/core_control_exc_prio_if.sv
// Exception prioritiser bus: fault/IRQ sources in, locked cause/mode/vector out.
// Master drives the sources and the sequencer handshake; slave is the prioritiser.
interface core_control_exc_prio_if #(
  parameter int IRQ_LINES = 4
);
  logic                 issue;
  logic                 escalate;
  logic [IRQ_LINES-1:0] irq_lines;
  logic [IRQ_LINES-1:0] irq_enable;
  logic [IRQ_LINES-1:0] irq_clear;
  logic                 fiq;
  logic                 mask_i;
  logic                 mask_f;
  logic                 high_vectors;
  logic                 mem_fault;
  logic                 prefetch_abort;
  logic                 undefined;
  logic                 swi;

  logic                 exception;
  logic [2:0]           exception_cause;
  logic [4:0]           exception_mode;
  logic [31:0]          exception_vector;
  logic                 exception_offset_pc;
  logic [IRQ_LINES-1:0] irq_status;

  modport master (
    output issue, escalate, irq_lines, irq_enable, irq_clear, fiq, mask_i, mask_f,
           high_vectors, mem_fault, prefetch_abort, undefined, swi,
    input  exception, exception_cause, exception_mode, exception_vector,
           exception_offset_pc, irq_status
  );

  modport slave (
    input  issue, escalate, irq_lines, irq_enable, irq_clear, fiq, mask_i, mask_f,
           high_vectors, mem_fault, prefetch_abort, undefined, swi,
    output exception, exception_cause, exception_mode, exception_vector,
           exception_offset_pc, irq_status
  );
endinterface

// File: rtl/core_control_exc_prio.sv
// Exception prioritiser: winning source locked one cycle after it asserts; IRQ/FIQ via issue-sampled pending bits.
// No backpressure: cause is held in LOCKED until escalate, then one blanking ENTRY cycle.
module core_control_exc_prio #(
  parameter int                   IRQ_LINES = 4,
  parameter logic [IRQ_LINES-1:0] EDGE_MASK = '0,
  parameter logic [15:0]          HIGH_BASE = 16'hFFFF
) (
  input logic                    clk,
  input logic                    rst_n,
  core_control_exc_prio_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_ENTRY} state_t;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_DABT = 3'd1;
  localparam logic [2:0] C_FIQ  = 3'd2;
  localparam logic [2:0] C_IRQ  = 3'd3;
  localparam logic [2:0] C_PABT = 3'd4;
  localparam logic [2:0] C_UND  = 3'd5;
  localparam logic [2:0] C_SWI  = 3'd6;

  state_t               state_q, state_d;
  logic [IRQ_LINES-1:0] prev_q, prev_d;
  logic [IRQ_LINES-1:0] latch_q, latch_d;
  logic [IRQ_LINES-1:0] irq_status_q, irq_status_d;
  logic                 pend_irq_q, pend_irq_d;
  logic                 pend_fiq_q, pend_fiq_d;
  logic                 exception_q, exception_d;
  logic [2:0]           cause_q, cause_d;
  logic [4:0]           mode_q, mode_d;
  logic [31:0]          vector_q, vector_d;
  logic                 offset_q, offset_d;
  logic [2:0]           win;
  logic                 capture;

  function automatic logic [4:0] mode_of(input logic [2:0] c);
    case (c)
      C_DABT, C_PABT: mode_of = 5'b10111;
      C_FIQ:          mode_of = 5'b10001;
      C_IRQ:          mode_of = 5'b10010;
      C_UND:          mode_of = 5'b11011;
      C_SWI:          mode_of = 5'b10011;
      default:        mode_of = 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] vec_off(input logic [2:0] c);
    case (c)
      C_DABT:  vec_off = 3'b100;
      C_FIQ:   vec_off = 3'b111;
      C_IRQ:   vec_off = 3'b110;
      C_PABT:  vec_off = 3'b011;
      C_UND:   vec_off = 3'b001;
      C_SWI:   vec_off = 3'b010;
      default: vec_off = 3'b000;
    endcase
  endfunction

  // Lowest code wins; later assignments override earlier ones.
  always_comb begin
    win = C_NONE;
    if (bus.swi)            win = C_SWI;
    if (bus.undefined)      win = C_UND;
    if (bus.prefetch_abort) win = C_PABT;
    if (pend_irq_q)         win = C_IRQ;
    if (pend_fiq_q)         win = C_FIQ;
    if (bus.mem_fault)      win = C_DABT;
  end

  always_comb begin
    prev_d       = bus.irq_lines;
    // A new edge beats a simultaneous clear so no request is lost.
    latch_d      = EDGE_MASK & ((latch_q & ~bus.irq_clear) | (bus.irq_lines & ~prev_q));
    irq_status_d = ((EDGE_MASK & latch_d) | (~EDGE_MASK & bus.irq_lines)) & bus.irq_enable;

    pend_irq_d = pend_irq_q;
    pend_fiq_d = pend_fiq_q;
    if (bus.issue) begin
      pend_irq_d = (|irq_status_q) & ~bus.mask_i;
      pend_fiq_d = bus.fiq & ~bus.mask_f;
    end

    state_d  = state_q;
    capture  = 1'b0;
    cause_d  = cause_q;
    mode_d   = mode_q;
    vector_d = vector_q;
    offset_d = offset_q;

    case (state_q)
      S_IDLE: begin
        if (win != C_NONE) begin
          capture = 1'b1;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (bus.escalate) begin
          state_d = S_ENTRY;
        end else if (win != C_NONE && win < cause_q) begin
          capture = 1'b1;
        end
      end
      S_ENTRY: begin
        // Sources are blanked here while the sequencer updates the CPSR masks.
        state_d = S_IDLE;
        if (cause_q == C_IRQ) pend_irq_d = 1'b0;
        if (cause_q == C_FIQ) pend_fiq_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      cause_d  = win;
      mode_d   = mode_of(win);
      vector_d = {(bus.high_vectors ? HIGH_BASE : 16'h0000), 11'b0, vec_off(win), 2'b00};
      offset_d = (win != C_DABT);
    end

    exception_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      latch_q      <= '0;
      irq_status_q <= '0;
      pend_irq_q   <= 1'b0;
      pend_fiq_q   <= 1'b0;
      exception_q  <= 1'b0;
      cause_q      <= C_NONE;
      mode_q       <= 5'b0;
      vector_q     <= 32'b0;
      offset_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      latch_q      <= latch_d;
      irq_status_q <= irq_status_d;
      pend_irq_q   <= pend_irq_d;
      pend_fiq_q   <= pend_fiq_d;
      exception_q  <= exception_d;
      cause_q      <= cause_d;
      mode_q       <= mode_d;
      vector_q     <= vector_d;
      offset_q     <= offset_d;
    end
  end

  assign bus.exception           = exception_q;
  assign bus.exception_cause     = cause_q;
  assign bus.exception_mode      = mode_q;
  assign bus.exception_vector    = vector_q;
  assign bus.exception_offset_pc = offset_q;
  assign bus.irq_status          = irq_status_q;

endmodule

// File: tb/tb_core_control_exc_prio.sv
// Directed bench for the exception prioritiser; expectations are cycle-stamped into a scoreboard.
module tb_core_control_exc_prio;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_control_exc_prio_if #(.IRQ_LINES(4)) bus ();

  core_control_exc_prio #(
    .IRQ_LINES(4),
    .EDGE_MASK(4'b0010),
    .HIGH_BASE(16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Observed word: {exception, cause[2:0], mode[4:0], vector[31:0], offset_pc, irq_status[3:0]}
  typedef struct {
    int          cyc;
    string       name;
    logic [45:0] val;
    logic [45:0] msk;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int c, input string nm, input logic [45:0] v, input logic [45:0] m);
    exp_t e;
    e.cyc = c; e.name = nm; e.val = v; e.msk = m;
    sb.push_back(e);
  endtask

  task automatic push_out(input int c, input string nm, input logic exc, input logic [2:0] ca,
                          input logic [4:0] mo, input logic [31:0] ve, input logic of);
    push(c, nm, {exc, ca, mo, ve, of, 4'b0000}, {1'b1, 3'h7, 5'h1F, 32'hFFFF_FFFF, 1'b1, 4'h0});
  endtask

  task automatic push_exc(input int c, input string nm, input logic exc);
    push(c, nm, {exc, 45'b0}, {1'b1, 45'b0});
  endtask

  task automatic push_st(input int c, input string nm, input logic [3:0] st);
    push(c, nm, {42'b0, st}, {42'b0, 4'hF});
  endtask

  task automatic push_zero(input int c, input string nm);
    push(c, nm, 46'b0, {46{1'b1}});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    logic [45:0] obs;
    obs = {bus.exception, bus.exception_cause, bus.exception_mode, bus.exception_vector,
           bus.exception_offset_pc, bus.irq_status};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_cmp++;
        if (sb[i].cyc < cyc) begin
          n_err++;
          $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", sb[i].name, sb[i].cyc, cyc);
        end else if ((obs & sb[i].msk) !== (sb[i].val & sb[i].msk)) begin
          n_err++;
          $display("FAIL %s @%0d: got %h want %h (mask %h)", sb[i].name, cyc,
                   obs & sb[i].msk, sb[i].val & sb[i].msk, sb[i].msk);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: never checked (cycle %0d)", sb[0].name, sb[0].cyc);
        void'(sb.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.issue = 0; bus.escalate = 0; bus.irq_lines = '0; bus.irq_enable = '0;
    bus.irq_clear = '0; bus.fiq = 0; bus.mask_i = 0; bus.mask_f = 0; bus.high_vectors = 0;
    bus.mem_fault = 0; bus.prefetch_abort = 0; bus.undefined = 0; bus.swi = 0;

    step(); push_zero(cyc, "reset");
    step(); push_zero(cyc, "reset_hold");
    rst_n = 1'b1;
    step();

    // Single UND trap, held until escalate, blanked in ENTRY.
    n = cyc; bus.undefined = 1;
    push_out(n + 1, "und", 1, 3'd5, 5'b11011, 32'h4, 1);
    push_out(n + 2, "und_hold", 1, 3'd5, 5'b11011, 32'h4, 1);
    step(); bus.undefined = 0;
    step(); bus.escalate = 1;
    push_exc(n + 3, "und_entry", 0);
    push_exc(n + 4, "und_idle", 0);
    step(); bus.escalate = 0;
    step();

    // DABT preempts UND; lower-priority SWI ignored while locked.
    n = cyc; bus.undefined = 1;
    push_out(n + 1, "pre_und1", 1, 3'd5, 5'b11011, 32'h4, 1);
    push_out(n + 2, "pre_und2", 1, 3'd5, 5'b11011, 32'h4, 1);
    push_out(n + 3, "dabt_preempt", 1, 3'd1, 5'b10111, 32'h10, 0);
    push_out(n + 4, "lower_ignored", 1, 3'd1, 5'b10111, 32'h10, 0);
    step(); bus.undefined = 0;
    step(); bus.mem_fault = 1;
    step(); bus.mem_fault = 0; bus.swi = 1;
    step(); bus.swi = 0; bus.escalate = 1;
    step(); bus.escalate = 0;
    step();

    // Escalate together with a higher source: held cause is used.
    n = cyc; bus.undefined = 1;
    step(); bus.undefined = 0; bus.escalate = 1; bus.mem_fault = 1;
    push_out(n + 2, "esc_wins", 0, 3'd5, 5'b11011, 32'h4, 1);
    push_exc(n + 3, "esc_idle", 0);
    step(); bus.escalate = 0; bus.mem_fault = 0;
    step(); step();

    // Edge IRQ on line 1 with high vectors; clear vs new edge.
    bus.high_vectors = 1; bus.irq_enable = 4'b1111;
    n = cyc; bus.irq_lines = 4'b0010;
    push_st(n + 1, "edge_status", 4'b0010);
    step(); bus.irq_lines = 4'b0000; bus.issue = 1;
    push_st(n + 2, "edge_latched", 4'b0010);
    push_exc(n + 2, "irq_pend_wait", 0);
    push_out(n + 3, "edge_irq", 1, 3'd3, 5'b10010, 32'hFFFF_0018, 1);
    step(); bus.issue = 0;
    step(); bus.escalate = 1;
    step(); bus.escalate = 0;
    push_exc(n + 5, "irq_pend_cleared", 0);
    step(); bus.irq_lines = 4'b0010; bus.irq_clear = 4'b0010;
    push_st(n + 6, "set_beats_clear", 4'b0010);
    step(); bus.irq_lines = 4'b0000;
    push_st(n + 7, "clear_latch", 4'b0000);
    push_exc(n + 7, "no_retake", 0);
    step(); bus.irq_clear = 4'b0000; bus.high_vectors = 0;
    step();

    // Level line 0 masked, then unmasked with FIQ at the same time.
    bus.mask_i = 1;
    n = cyc; bus.irq_lines = 4'b0001;
    push_st(n + 1, "level_status", 4'b0001);
    push_exc(n + 2, "masked1", 0);
    push_exc(n + 3, "masked2", 0);
    push_exc(n + 4, "unmask_wait", 0);
    push_out(n + 5, "fiq_over_irq", 1, 3'd2, 5'b10001, 32'h1C, 1);
    push_exc(n + 6, "fiq_entry", 0);
    push_out(n + 8, "irq_after_fiq", 1, 3'd3, 5'b10010, 32'h18, 1);
    push_exc(n + 10, "both_cleared", 0);
    step(); bus.issue = 1;
    step(); step();
    bus.mask_i = 0; bus.fiq = 1;
    step(); bus.issue = 0;
    step(); bus.escalate = 1;
    step(); bus.escalate = 0;
    step(); step(); bus.escalate = 1;
    step(); bus.escalate = 0;
    step(); bus.irq_lines = 4'b0000; bus.fiq = 0;
    step();

    // SWI held through escalate: blanked, then retaken.
    n = cyc; bus.swi = 1;
    push_out(n + 1, "swi", 1, 3'd6, 5'b10011, 32'h8, 1);
    push_exc(n + 2, "swi_blank", 0);
    push_exc(n + 3, "swi_idle", 0);
    push_out(n + 4, "swi_retake", 1, 3'd6, 5'b10011, 32'h8, 1);
    push_out(n + 5, "swi_held", 1, 3'd6, 5'b10011, 32'h8, 1);
    step(); bus.escalate = 1;
    step(); bus.escalate = 0;
    step(); step(); bus.swi = 0;
    step();

    // Reset while locked on DABT; edge line held high across release.
    n = cyc; bus.mem_fault = 1; bus.irq_lines = 4'b0010;
    push_out(n + 1, "dabt_before_rst", 1, 3'd1, 5'b10111, 32'h10, 0);
    push_zero(n + 2, "reset_mid");
    push_st(n + 3, "edge_after_rst", 4'b0010);
    push_exc(n + 3, "idle_after_rst", 0);
    step(); bus.mem_fault = 0; rst_n = 0;
    step(); rst_n = 1;
    step(); step(); bus.irq_lines = 4'b0000;
    step(); step();
    done = 1'b1;
  end

endmodule

// File: doc/core_control_exc_prio.md
# core_control_exc_prio

Parametrised exception prioritiser for the core control unit. It replaces the fixed single-IRQ exception logic with:
- a bank of `IRQ_LINES` interrupt inputs, each with a per-line level/edge mode and an enable;
- FIQ and SWI support;
- an explicit lock/entry state machine that holds the selected cause stable until the control FSM escalates.

It sits between the decode/memory fault sources and the control cycle sequencer. The sequencer reads its registered mode, vector and PC-offset outputs.

## Interface
Parameters:
- `IRQ_LINES`, 4: number of external IRQ inputs, ≥1.
- `EDGE_MASK`, `'0`: `IRQ_LINES`-bit; bit i=1 makes line i edge-triggered (latched), 0 makes it level-sensitive.
- `HIGH_BASE`, `16'hFFFF`: upper vector half used when `high_vectors`=1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `issue` in 1: instruction issue boundary; IRQ/FIQ pending bits sample here.
- `escalate` in 1: sequencer is entering the exception this cycle.
- `irq_lines` in `IRQ_LINES`: raw interrupt requests.
- `irq_enable` in `IRQ_LINES`: per-line enable.
- `irq_clear` in `IRQ_LINES`: write-1-to-clear for edge latches.
- `fiq` in 1: fast interrupt request, level.
- `mask_i`, `mask_f` in 1 each: CPSR I and F bits.
- `high_vectors` in 1: selects `HIGH_BASE`.
- `mem_fault`, `prefetch_abort`, `undefined`, `swi` in 1 each: synchronous fault/trap sources.
- `exception` out 1: a cause is locked and awaiting escalation.
- `exception_cause` out 3: 1 DABT, 2 FIQ, 3 IRQ, 4 PABT, 5 UND, 6 SWI, 0 none.
- `exception_mode` out 5: target mode.
- `exception_vector` out 32: target vector.
- `exception_offset_pc` out 1: 0 for DABT, 1 otherwise.
- `irq_status` out `IRQ_LINES`: per-line enabled request status.

## Operation
**IRQ aggregation**
- Per line, `prev[i]` is registered each cycle.
- Edge lines: `latch[i]` sets on `irq_lines[i] & !prev[i]` and clears on `irq_clear[i]`. If set and clear coincide, set wins.
- `irq_status[i]` = (edge ? `latch[i]` : `irq_lines[i]`) & `irq_enable[i]`. This output is registered.

**Pending bits** (update only when `issue`=1)
- `pend_irq` ← |`irq_status` & !`mask_i`.
- `pend_fiq` ← `fiq` & !`mask_f`.

**Priority**, highest first: DABT (`mem_fault`), FIQ (`pend_fiq`), IRQ (`pend_irq`), PABT, UND, SWI.

| Cause | Vector offset [4:2] | Mode |
|---|---|---|
| DABT | 100 | ABT 5'b10111 |
| FIQ | 111 | FIQ 5'b10001 |
| IRQ | 110 | IRQ 5'b10010 |
| PABT | 011 | ABT |
| UND | 001 | UND 5'b11011 |
| SWI | 010 | SVC 5'b10011 |

`exception_vector` = {`high_vectors` ? `HIGH_BASE` : 16'h0, 11'b0, offset, 2'b00}.

**FSM**
- **IDLE**
  - If any source is active, capture the winning cause into cause/mode/vector/offset registers and go to LOCKED.
  - Otherwise stay.
- **LOCKED**
  - `exception`=1.
  - A source with strictly higher priority than the held cause replaces it (re-registered, stays LOCKED).
  - Lower or equal priority sources are ignored.
  - A cause stays held even if its source deasserts.
  - On `escalate`, go to ENTRY.
- **ENTRY** (exactly 1 cycle)
  - `exception`=0 and all sources are ignored (blanking while the CPSR mask updates).
  - Clear `pend_irq` if the cause was IRQ; clear `pend_fiq` if the cause was FIQ.
  - Go to IDLE.
- `escalate` in IDLE or ENTRY is ignored.

## Timing
- Source asserted in cycle N (IDLE) → `exception`=1 and cause outputs valid in N+1.
- IRQ path: line change → `irq_status` at +1 → `pend_irq` at the next `issue` → `exception` one cycle after that.
- Preemption in LOCKED: the new cause is visible on outputs the cycle after the higher source asserts.
- `escalate` in cycle N → ENTRY in N+1 (`exception`=0) → IDLE in N+2. A source still active at N+2 is captured, giving `exception`=1 at N+3.
- `escalate` and a higher source in the same LOCKED cycle: escalate wins and the held cause is used.
- Reset values (synchronous, `rst_n`=0 at a clock edge):
  - state=IDLE;
  - `exception`=0, `exception_cause`=0, `exception_mode`=0, `exception_vector`=0, `exception_offset_pc`=0;
  - `irq_status`=0, latches=0, `prev`=0, `pend_*`=0.
- Because `prev` resets to 0, an edge line held high across reset release registers one edge.
- Reset mid-LOCKED discards the cause with no ENTRY cycle.

## Test plan
- **Single trap.** `undefined` pulsed for 1 cycle, `high_vectors`=0 → next cycle `exception`=1, cause 5, mode 11011, vector 32'h4, offset_pc 1. These outputs hold until `escalate`; `exception`=0 in ENTRY.
- **Priority and preemption.** `undefined` in cycle 0, `mem_fault` in cycle 2 → cause 5 in cycles 1–2, then cause 1 (mode 10111, vector 32'h10, offset_pc 0) from cycle 3.
- **Edge IRQ.** `EDGE_MASK`=4'b0010, `high_vectors`=1, line 1 pulsed, enabled, `mask_i`=0, `issue` next cycle → `irq_status`=4'b0010, then `exception`=1, cause 3, vector 32'hFFFF0018. `irq_clear`[1] coinciding with a new edge leaves the latch set.
- **Masking.** Level line 0 held high with `mask_i`=1 across issues → `exception` stays 0. Drop `mask_i` and issue → IRQ is taken. FIQ raised at the same time as the IRQ → cause 2, vector 32'h1C.
- **Blanking and retake.** SWI held high through `escalate` → ENTRY cycle has `exception`=0, then cause 6 (mode 10011, vector 32'h8) is re-asserted two cycles after ENTRY.
- **Reset mid-operation.** `rst_n`=0 for 1 cycle while LOCKED with DABT → all outputs 0 the next cycle. An edge line held high before release yields `irq_status` bit 1 after release.
